// File: rtl/maxpool_batch_scheduler.sv
// Batch sequencer for the 2x2 max-pool engine: launches one image at a time,
// then shares the engine's pooled-output read port between two consumers.
module maxpool_batch_scheduler #(
   parameter int unsigned NUM_IMAGES = 16,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned TIMEOUT    = 32'd50_000_000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              batch_start,
   output logic              busy,
   output logic              batch_done,
   output logic              error,
   output logic [4:0]        cur_image,
   output logic              image_ready,
   input  logic              image_release,
   output logic              pool_start,
   output logic [4:0]        pool_image_index,
   input  logic              pool_done,
   output logic [ADDR_W-1:0] pool_read_addr,
   input  logic [DATA_W-1:0] pool_read_data,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned IDX_W = 5;
   localparam int unsigned CNT_W = 32;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IMAGES - 1);
   // Counter is cleared in LAUNCH and first increments one cycle later, so the
   // limit is offset to measure TIMEOUT cycles from the pool_start cycle.
   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT - 2);

   localparam logic [1:0] RD_IDLE = 2'd0;
   localparam logic [1:0] RD_ADDR = 2'd1;
   localparam logic [1:0] RD_DATA = 2'd2;

   typedef enum logic [2:0] {IDLE, LAUNCH, RUN, AVAIL, DRAIN, FINISH} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] tmo_cnt;
   logic [1:0]       rd_phase;
   logic             rd_sel;
   logic             prio1;
   logic             grant_ok;
   logic             pick1;
   logic             step;

   assign cur_image        = idx;
   assign pool_image_index = idx;

   // Grant/advance decisions; release always beats a pending request.
   always_comb begin
      grant_ok = (state == AVAIL) && !image_release && (rd_phase == RD_IDLE) && (req0 || req1);
      pick1    = req1 && (!req0 || prio1);
      step     = ((state == AVAIL) && image_release && (rd_phase == RD_IDLE)) ||
                 ((state == DRAIN) && (rd_phase == RD_IDLE));
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state          <= IDLE;
         idx            <= '0;
         tmo_cnt        <= '0;
         rd_phase       <= RD_IDLE;
         rd_sel         <= 1'b0;
         prio1          <= 1'b0;
         busy           <= 1'b0;
         batch_done     <= 1'b0;
         error          <= 1'b0;
         image_ready    <= 1'b0;
         pool_start     <= 1'b0;
         pool_read_addr <= '0;
         gnt0           <= 1'b0;
         gnt1           <= 1'b0;
         rvalid0        <= 1'b0;
         rvalid1        <= 1'b0;
         rdata          <= '0;
      end else begin
         pool_start  <= 1'b0;
         image_ready <= 1'b0;
         batch_done  <= 1'b0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;

         // Read pipeline: address held for the BRAM latency, data captured two edges later.
         if (grant_ok) begin
            rd_phase       <= RD_ADDR;
            rd_sel         <= pick1;
            prio1          <= !pick1;
            pool_read_addr <= pick1 ? addr1 : addr0;
            gnt0           <= !pick1;
            gnt1           <= pick1;
         end else if (rd_phase == RD_ADDR) begin
            rd_phase <= RD_DATA;
         end else if (rd_phase == RD_DATA) begin
            rd_phase <= RD_IDLE;
            rdata    <= pool_read_data;
            rvalid0  <= !rd_sel;
            rvalid1  <= rd_sel;
         end

         case (state)
            IDLE: begin
               if (batch_start) begin
                  idx        <= '0;
                  error      <= 1'b0;
                  busy       <= 1'b1;
                  pool_start <= 1'b1;
                  state      <= LAUNCH;
               end
            end
            LAUNCH: begin
               tmo_cnt <= '0;
               state   <= RUN;
            end
            RUN: begin
               if (pool_done) begin
                  image_ready <= 1'b1;
                  state       <= AVAIL;
               end else if (tmo_cnt == TMO_LIMIT) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            AVAIL, DRAIN: begin
               if (step) begin
                  if (idx == LAST_IDX) begin
                     batch_done <= 1'b1;
                     state      <= FINISH;
                  end else begin
                     idx        <= idx + IDX_W'(1);
                     pool_start <= 1'b1;
                     state      <= LAUNCH;
                  end
               end else if ((state == AVAIL) && image_release) begin
                  state <= DRAIN;
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
